// File: rtl/tdes_pkg.sv
// Shared types and widths for the three-DES output stage.
package tdes_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned WORD_W  = 32;

  typedef logic [BLOCK_W-1:0] tdes_block_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

endpackage

// File: rtl/tdes_block_fifo.sv
// Circular block buffer; a push while full is accepted only alongside a pop.
module tdes_block_fifo
  import tdes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  tdes_block_t              push_data,
  input  logic                     pop,
  output tdes_block_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  tdes_block_t     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tdes_output_buffer.sv
// Queues 64-bit cipher results and streams them as HI then LO 32-bit words.
module tdes_output_buffer
  import tdes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_ready,
  input  logic [BLOCK_W-1:0]       data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  phase_e      phase_q, phase_d;
  logic        overflow_q, overflow_d;
  tdes_block_t head;
  logic        full, empty;
  logic        xfer, pop_block, drop;

  tdes_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_ready),
    .push_data (data_in),
    .pop       (pop_block),
    .head      (head),
    .count     (level),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign xfer      = out_valid && out_ready;
  assign pop_block = xfer && (phase_q == PH_LO);
  assign drop      = data_ready && full && !pop_block;

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (xfer) phase_d = (phase_q == PH_HI) ? PH_LO : PH_HI;
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_HI;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (!empty) begin
      unique case (phase_q)
        PH_HI: out_data = head[BLOCK_W-1:WORD_W];
        PH_LO: begin
          out_data = head[WORD_W-1:0];
          out_last = 1'b1;
        end
        default: out_data = '0;
      endcase
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_tdes_output_buffer.sv
// Directed bench for tdes_output_buffer with a queue-level reference model.
module tb_tdes_output_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready = 1'b0;
  logic [63:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  level;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: list of stored blocks, which half of the head is shown, sticky flag.
  logic [63:0] mq[$];
  logic        mlo = 1'b0;
  logic        movf = 1'b0;

  logic [31:0] rx[$];
  logic [31:0] ew[$];

  tdes_output_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_ready     (data_ready),
    .data_in        (data_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every clock edge, or immediately on reset.
  initial begin
    logic xfer, fin, acc;
    logic [63:0] tmp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mlo  = 1'b0;
        movf = 1'b0;
      end else begin
        xfer = (mq.size() != 0) && out_ready;
        fin  = xfer && mlo;
        acc  = data_ready && ((mq.size() < DEPTH) || fin);
        if (xfer) begin
          if (mlo) begin
            tmp = mq.pop_front();
            mlo = 1'b0;
          end else begin
            mlo = 1'b1;
          end
        end
        if (acc) mq.push_back(data_in);
        if (data_ready && !acc) movf = 1'b1;
        else if (clear_overflow) movf = 1'b0;
      end
    end
  end

  // Compare and transfer log, away from the active edge.
  initial begin
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      ed = '0;
      if (mq.size() != 0) ed = mlo ? mq[0][31:0] : mq[0][63:32];
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("out_data",  64'(out_data),  64'(ed));
      chk("out_last",  64'(out_last),  64'((mq.size() != 0) && mlo));
      chk("level",     64'(level),     64'(mq.size()));
      chk("overflow",  64'(overflow),  64'(movf));
      if (out_valid && out_ready && !rst) rx.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] b);
    data_ready = 1'b1;
    data_in    = b;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic expect_block(input logic [63:0] b);
    ew.push_back(b[63:32]);
    ew.push_back(b[31:0]);
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, 64'(rx.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < rx.size(); i++) chk(name, 64'(rx[i]), 64'(ew[i]));
    rx.delete();
    ew.delete();
  endtask

  initial begin
    logic [63:0] blk;
    // Reset state
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    rx.delete();

    // Single block
    out_ready = 1'b1;
    push(64'h0123456789ABCDEF);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_hi", 64'(out_data), 64'h01234567);
    chk("single_hi_last", 64'(out_last), 64'd0);
    tick();
    chk("single_lo", 64'(out_data), 64'h89ABCDEF);
    chk("single_lo_last", 64'(out_last), 64'd1);
    tick();
    chk("single_level", 64'(level), 64'd0);
    expect_block(64'h0123456789ABCDEF);
    check_rx("single_rx");

    // Back-pressure and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blk = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      push(blk);
      expect_block(blk);
    end
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_ovf", 64'(overflow), 64'd0);
    chk("bp_stable", 64'(out_data), 64'hA0000000);
    push(64'hDEAD_BEEF_DEAD_BEEF);
    chk("bp_ovf_set", 64'(overflow), 64'd1);
    chk("bp_level_hold", 64'(level), 64'd4);
    out_ready = 1'b1;
    repeat (9) tick();
    check_rx("bp_rx");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("bp_ovf_clr", 64'(overflow), 64'd0);

    // Full with simultaneous final pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blk = {32'hC100_0000 + 32'(i), 32'hC200_0000 + 32'(i)};
      push(blk);
      expect_block(blk);
    end
    out_ready = 1'b1;
    tick();
    chk("fp_in_lo", 64'(out_last), 64'd1);
    push(64'h5555_6666_7777_8888);
    expect_block(64'h5555_6666_7777_8888);
    chk("fp_level", 64'(level), 64'd4);
    chk("fp_ovf", 64'(overflow), 64'd0);
    repeat (10) tick();
    check_rx("fp_rx");

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      blk = {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i)};
      expect_block(blk);
      push(blk);
      chk("wrap_level_max", 64'(level <= 3'd1), 64'd1);
      tick();
      chk("wrap_level_max", 64'(level <= 3'd1), 64'd1);
    end
    repeat (2) tick();
    check_rx("wrap_rx");

    // Random stalling
    for (int i = 0; i < 6; i++) begin
      blk = {32'h3300_0000 + 32'(i * 7), 32'h4400_0000 + 32'(i * 13)};
      expect_block(blk);
      out_ready = ($urandom_range(0, 3) != 0) || (level >= 3'd3);
      push(blk);
      for (int k = 0; k < 3; k++) begin
        out_ready = ($urandom_range(0, 3) != 0) || (level >= 3'd3);
        tick();
      end
    end
    out_ready = 1'b1;
    repeat (12) tick();
    check_rx("stall_rx");

    // Reset during LO, with overflow already set
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push({32'h7700_0000 + 32'(i), 32'h8800_0000});
    chk("rs_pre_ovf", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rs_pre_lo", 64'(out_last), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_data", 64'(out_data), 64'd0);
    chk("rs_last", 64'(out_last), 64'd0);
    chk("rs_level", 64'(level), 64'd0);
    chk("rs_ovf", 64'(overflow), 64'd0);
    tick();
    rst = 1'b0;
    rx.delete();
    out_ready = 1'b1;
    push(64'hFEED_FACE_CAFE_F00D);
    expect_block(64'hFEED_FACE_CAFE_F00D);
    repeat (3) tick();
    check_rx("rs_rx");

    // Clear coinciding with a drop keeps the flag
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push({32'h9900_0000 + 32'(i), 32'h0});
    chk("cd_ovf_set", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    push(64'h1);
    chk("cd_ovf_hold", 64'(overflow), 64'd1);
    tick();
    clear_overflow = 1'b0;
    chk("cd_ovf_clr", 64'(overflow), 64'd0);
    chk("cd_level", 64'(level), 64'd4);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
